// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one sequential multiplier among NUM_REQ requesters.
// Optional watchdog enabled by defining MULT_ARB_TIMEOUT_EN.
module mult_share_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned A_W         = 3,
  parameter int unsigned B_W         = 3,
  parameter int unsigned P_W         = 6,
  parameter int unsigned TIMEOUT_CYC = 32
) (
  input  logic                   SYS_CLOCK,
  input  logic                   FSM_ARESET,
  input  logic [NUM_REQ-1:0]     REQ,
  input  logic [NUM_REQ*A_W-1:0] REQ_A,
  input  logic [NUM_REQ*B_W-1:0] REQ_B,
  output logic [NUM_REQ-1:0]     GNT,
  output logic [NUM_REQ-1:0]     DONE,
  output logic [P_W-1:0]         RESULT,
  output logic                   BUSY,
  output logic                   ERR,
  output logic                   M_GO,
  output logic [A_W-1:0]         M_A,
  output logic [B_W-1:0]         M_B,
  input  logic                   M_READY,
  input  logic [P_W-1:0]         M_F
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (P_W != A_W + B_W) begin : g_bad_pw
    $error("P_W must equal A_W+B_W");
  end
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("NUM_REQ must be in 2..8");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_DONE,
    RESPOND
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   ptr, ptr_nxt;
  logic [IDX_W-1:0]   winner, winner_nxt;
  logic [IDX_W-1:0]   pick;
  logic               pick_valid;
  int unsigned        scan;
  logic [IDX_W-1:0]   scan_idx;
  logic [A_W-1:0]     m_a_nxt;
  logic [B_W-1:0]     m_b_nxt;
  logic [P_W-1:0]     result_nxt;
  logic [NUM_REQ-1:0] win_oh;

  // First set request at or above the pointer, wrapping past NUM_REQ-1.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    scan       = 0;
    scan_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan = 32'(ptr) + k;
      if (scan >= NUM_REQ) scan = scan - NUM_REQ;
      scan_idx = IDX_W'(scan);
      if (!pick_valid && REQ[scan_idx]) begin
        pick       = scan_idx;
        pick_valid = 1'b1;
      end
    end
  end

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             timeout_hit;
`endif

  always_comb begin
    state_nxt  = state;
    winner_nxt = winner;
    ptr_nxt    = ptr;
    m_a_nxt    = M_A;
    m_b_nxt    = M_B;
    result_nxt = RESULT;
    unique case (state)
      IDLE: begin
        if (pick_valid && M_READY) begin
          state_nxt  = ISSUE;
          winner_nxt = pick;
          m_a_nxt    = REQ_A[pick*A_W +: A_W];
          m_b_nxt    = REQ_B[pick*B_W +: B_W];
        end
      end
      ISSUE:      state_nxt = WAIT_START;
      WAIT_START: if (!M_READY) state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (M_READY) begin
          result_nxt = M_F;
          state_nxt  = RESPOND;
        end
      end
      RESPOND: begin
        state_nxt = IDLE;
        ptr_nxt   = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + IDX_W'(1);
        m_a_nxt   = '0;
        m_b_nxt   = '0;
      end
      default: state_nxt = IDLE;
    endcase
`ifdef MULT_ARB_TIMEOUT_EN
    timeout_hit = 1'b0;
    cnt_nxt     = cnt;
    if (state_nxt == ISSUE) begin
      cnt_nxt = '0;
    end else if (state == WAIT_START || state == WAIT_DONE) begin
      cnt_nxt = cnt + CNT_W'(1);
      // A genuine completion on the limit cycle wins over the watchdog.
      if (cnt >= CNT_W'(TIMEOUT_CYC - 1) && state_nxt != RESPOND) begin
        timeout_hit = 1'b1;
        state_nxt   = RESPOND;
        result_nxt  = '0;
      end
    end
`endif
  end

  assign win_oh = NUM_REQ'(1) << winner_nxt;

  // Outputs are registered from the next-state decode so they line up with the state.
  always_ff @(posedge SYS_CLOCK) begin
    if (FSM_ARESET) begin
      state  <= IDLE;
      ptr    <= '0;
      winner <= '0;
      GNT    <= '0;
      DONE   <= '0;
      RESULT <= '0;
      BUSY   <= 1'b0;
      M_GO   <= 1'b0;
      M_A    <= '0;
      M_B    <= '0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      winner <= winner_nxt;
      GNT    <= (state_nxt == ISSUE) ? win_oh : '0;
      DONE   <= (state_nxt == RESPOND) ? win_oh : '0;
      RESULT <= result_nxt;
      BUSY   <= (state_nxt != IDLE);
      M_GO   <= (state_nxt == ISSUE);
      M_A    <= m_a_nxt;
      M_B    <= m_b_nxt;
    end
  end

`ifdef MULT_ARB_TIMEOUT_EN
  always_ff @(posedge SYS_CLOCK) begin
    if (FSM_ARESET) begin
      cnt <= '0;
      ERR <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      ERR <= timeout_hit;
    end
  end
`else
  assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Scoreboard bench for mult_share_arbiter with a behavioural 3x3 sequential multiplier.
// Directed vectors push expected grants/results; a negedge monitor pops and compares.
module tb_mult_share_arbiter;

  localparam int MUL_LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  REQ = '0;
  logic [11:0] REQ_A = '0;
  logic [11:0] REQ_B = '0;
  logic [3:0]  GNT, DONE;
  logic [5:0]  RESULT;
  logic        BUSY, ERR, M_GO;
  logic [2:0]  M_A, M_B;
  logic        m_ready;
  logic [5:0]  m_f;

  always #5 clk = ~clk;

  mult_share_arbiter #(
    .NUM_REQ(4), .A_W(3), .B_W(3), .P_W(6), .TIMEOUT_CYC(8)
  ) dut (
    .SYS_CLOCK(clk), .FSM_ARESET(rst), .REQ(REQ), .REQ_A(REQ_A), .REQ_B(REQ_B),
    .GNT(GNT), .DONE(DONE), .RESULT(RESULT), .BUSY(BUSY), .ERR(ERR),
    .M_GO(M_GO), .M_A(M_A), .M_B(M_B), .M_READY(m_ready), .M_F(m_f)
  );

  // Multiplier: GO accepted at an edge, one setup cycle with READY still high,
  // then READY low for MUL_LAT cycles, then READY high with the product.
  logic [1:0] m_ph;
  logic [5:0] m_prod;
  int         m_cnt;
  logic       stuck = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_ready <= 1'b1;
      m_f     <= '0;
      m_ph    <= 2'd0;
      m_cnt   <= 0;
      m_prod  <= '0;
    end else begin
      case (m_ph)
        2'd0: if (M_GO && m_ready) begin
          m_prod <= 6'(M_A) * 6'(M_B);
          m_ph   <= 2'd1;
        end
        2'd1: begin
          m_ready <= 1'b0;
          m_f     <= 6'h2A;
          m_cnt   <= 1;
          m_ph    <= 2'd2;
        end
        default: begin
          if (!stuck && m_cnt == MUL_LAT) begin
            m_ready <= 1'b1;
            m_f     <= m_prod;
            m_ph    <= 2'd0;
          end else begin
            m_cnt <= m_cnt + 1;
          end
        end
      endcase
    end
  end

  typedef struct { logic [3:0] oh; logic [2:0] a; logic [2:0] b; } gnt_t;
  typedef struct { logic [3:0] oh; logic [5:0] res; logic err; int lat; } done_t;

  gnt_t  gq[$];
  done_t dq[$];
  gnt_t  g_cur;
  done_t d_cur;
  int    checks = 0;
  int    fails = 0;
  int    gnt_seen = 0;
  int    done_seen = 0;
  int    cyc = 0;
  int    gnt_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (|GNT) begin
        gnt_seen++;
        gnt_cyc = cyc;
        if (gq.size() == 0) begin
          check("unexpected_gnt", 32'(GNT), 0);
        end else begin
          g_cur = gq.pop_front();
          check("gnt", 32'(GNT), 32'(g_cur.oh));
          check("m_go", 32'(M_GO), 1);
          check("busy_at_gnt", 32'(BUSY), 1);
          check("m_a", 32'(M_A), 32'(g_cur.a));
          check("m_b", 32'(M_B), 32'(g_cur.b));
        end
      end
      if (|DONE) begin
        done_seen++;
        if (dq.size() == 0) begin
          check("unexpected_done", 32'(DONE), 0);
        end else begin
          d_cur = dq.pop_front();
          check("done", 32'(DONE), 32'(d_cur.oh));
          check("result", 32'(RESULT), 32'(d_cur.res));
          check("err", 32'(ERR), 32'(d_cur.err));
          check("latency", cyc - gnt_cyc, d_cur.lat);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_ops(input int i, input logic [2:0] a, input logic [2:0] b);
    REQ_A[i*3 +: 3] = a;
    REQ_B[i*3 +: 3] = b;
  endtask

  task automatic expect_op(input logic [3:0] oh, input logic [2:0] a, input logic [2:0] b,
                           input logic [5:0] res, input logic err, input int lat);
    gq.push_back('{oh: oh, a: a, b: b});
    dq.push_back('{oh: oh, res: res, err: err, lat: lat});
  endtask

  task automatic wait_gnts(input int target);
    int budget = 0;
    while (gnt_seen < target && budget < 300) begin
      tick(1);
      budget++;
    end
    if (gnt_seen < target) check("gnt_wait", gnt_seen, target);
  endtask

  // Holds REQ until n grants, then drops REQ and scrambles operands before completion.
  task automatic serve(input logic [3:0] req, input int n);
    int d0 = done_seen;
    int budget = 0;
    REQ = req;
    wait_gnts(gnt_seen + n);
    REQ   = '0;
    REQ_A = '1;
    REQ_B = '1;
    while (done_seen < d0 + n && budget < 300) begin
      tick(1);
      budget++;
    end
    if (done_seen < d0 + n) check("done_wait", done_seen, d0 + n);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_gnt"}, 32'(GNT), 0);
    check({tag, "_done"}, 32'(DONE), 0);
    check({tag, "_result"}, 32'(RESULT), 0);
    check({tag, "_busy"}, 32'(BUSY), 0);
    check({tag, "_err"}, 32'(ERR), 0);
    check({tag, "_m_go"}, 32'(M_GO), 0);
    check({tag, "_m_a"}, 32'(M_A), 0);
    check({tag, "_m_b"}, 32'(M_B), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    tick(3);
    check_quiet("reset");
    rst = 1'b0;
    tick(2);

    // Contention from pointer 0: grants 0,1,2,3,0.
    set_ops(0, 3'd1, 3'd7);
    set_ops(1, 3'd2, 3'd7);
    set_ops(2, 3'd3, 3'd7);
    set_ops(3, 3'd4, 3'd7);
    expect_op(4'b0001, 3'd1, 3'd7, 6'd7,  1'b0, 7);
    expect_op(4'b0010, 3'd2, 3'd7, 6'd14, 1'b0, 7);
    expect_op(4'b0100, 3'd3, 3'd7, 6'd21, 1'b0, 7);
    expect_op(4'b1000, 3'd4, 3'd7, 6'd28, 1'b0, 7);
    expect_op(4'b0001, 3'd1, 3'd7, 6'd7,  1'b0, 7);
    serve(4'b1111, 5);
    tick(2);

    // Single request, multiplier latency 4: DONE 7 cycles after GNT.
    set_ops(0, 3'd5, 3'd7);
    expect_op(4'b0001, 3'd5, 3'd7, 6'd35, 1'b0, 7);
    serve(4'b0001, 1);
    tick(1);

    // Pointer wrap: grant 3, then 1001 goes to 0 then 3.
    set_ops(3, 3'd2, 3'd3);
    expect_op(4'b1000, 3'd2, 3'd3, 6'd6, 1'b0, 7);
    serve(4'b1000, 1);
    set_ops(0, 3'd4, 3'd4);
    set_ops(3, 3'd2, 3'd3);
    expect_op(4'b0001, 3'd4, 3'd4, 6'd16, 1'b0, 7);
    expect_op(4'b1000, 3'd2, 3'd3, 6'd6,  1'b0, 7);
    serve(4'b1001, 2);
    tick(3);

    // Max operands, REQ dropped and operands changed right after GNT.
    set_ops(2, 3'd7, 3'd7);
    expect_op(4'b0100, 3'd7, 3'd7, 6'd49, 1'b0, 7);
    serve(4'b0100, 1);
    tick(2);

    // Reset in WAIT_DONE: everything clears, no DONE, pointer back to 0.
    set_ops(2, 3'd6, 3'd5);
    gq.push_back('{oh: 4'b0100, a: 3'd6, b: 3'd5});
    REQ = 4'b0100;
    wait_gnts(gnt_seen + 1);
    REQ = '0;
    tick(3);
    rst = 1'b1;
    tick(1);
    check_quiet("midreset");
    rst = 1'b0;
    tick(15);
    set_ops(0, 3'd1, 3'd7);
    set_ops(1, 3'd3, 3'd2);
    set_ops(2, 3'd3, 3'd2);
    set_ops(3, 3'd3, 3'd2);
    expect_op(4'b0001, 3'd1, 3'd7, 6'd7, 1'b0, 7);
    serve(4'b1111, 1);
    tick(2);

    // Multiplier READY stuck low after accepting GO.
    stuck = 1'b1;
    set_ops(1, 3'd3, 3'd3);
`ifdef MULT_ARB_TIMEOUT_EN
    expect_op(4'b0010, 3'd3, 3'd3, 6'd0, 1'b1, 9);
    serve(4'b0010, 1);
`else
    gq.push_back('{oh: 4'b0010, a: 3'd3, b: 3'd3});
    REQ = 4'b0010;
    wait_gnts(gnt_seen + 1);
    REQ = '0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      check("busy_hold", 32'(BUSY), 1);
    end
`endif
    rst   = 1'b1;
    stuck = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(2);

    check("gnt_queue_empty", gq.size(), 0);
    check("done_queue_empty", dq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
